// File: rtl/bram_pkg.sv
// Shared constants and helpers for the byte-enabled true dual-port block RAM.
package bram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  // Widest word the merge helper handles. Callers zero-extend to this width
  // and slice the result back down to their own width.
  localparam int MAX_DATA  = 256;
  localparam int MAX_BYTES = MAX_DATA / 8;

  // Returns old_word with every lane whose enable bit is set taken from new_word.
  function automatic logic [MAX_DATA-1:0] byte_merge(
    input logic [MAX_DATA-1:0]  old_word,
    input logic [MAX_DATA-1:0]  new_word,
    input logic [MAX_BYTES-1:0] we
  );
    logic [MAX_DATA-1:0] w;
    w = old_word;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (we[i]) w[8*i +: 8] = new_word[8*i +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/bram_rdport.sv
// Read path of one RAM port: read-during-write select, cross-port bypass
// and optional output pipeline register.
module bram_rdport
  import bram_pkg::*;
#(
  parameter int DATA     = 32,
  parameter int ADDR     = 10,
  parameter int RDW_MODE = RDW_READ_FIRST,
  parameter int OUTREG   = 0,
  // 1 when this port's write wins overlapping lanes (port A), 0 otherwise.
  parameter int OWN_WINS = 1,
  localparam int BYTES   = DATA / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [BYTES-1:0] we,
  input  logic [ADDR-1:0]  addr,
  input  logic [DATA-1:0]  write,
  input  logic             other_ce,
  input  logic [BYTES-1:0] other_we,
  input  logic [ADDR-1:0]  other_addr,
  input  logic [DATA-1:0]  other_write,
  input  logic [DATA-1:0]  mem_word,
  output logic [DATA-1:0]  read
);

  logic [BYTES-1:0]    own_lanes;
  logic [BYTES-1:0]    other_lanes;
  logic [MAX_DATA-1:0] fwd;
  logic [DATA-1:0]     next_word;
  logic [DATA-1:0]     stage1;
  logic                unused_fwd_hi;

  // Build the post-write word at this address: both ports' lanes applied in
  // priority order, so the winner of an overlap is applied last.
  always_comb begin
    own_lanes   = ce ? we : '0;
    other_lanes = (other_ce && (other_addr == addr)) ? other_we : '0;
    if (OWN_WINS != 0) begin
      fwd = byte_merge(MAX_DATA'(mem_word), MAX_DATA'(other_write), MAX_BYTES'(other_lanes));
      fwd = byte_merge(fwd, MAX_DATA'(write), MAX_BYTES'(own_lanes));
    end else begin
      fwd = byte_merge(MAX_DATA'(mem_word), MAX_DATA'(write), MAX_BYTES'(own_lanes));
      fwd = byte_merge(fwd, MAX_DATA'(other_write), MAX_BYTES'(other_lanes));
    end
    next_word = (RDW_MODE == RDW_WRITE_FIRST) ? fwd[DATA-1:0] : mem_word;
  end

  assign unused_fwd_hi = ^fwd[MAX_DATA-1:DATA];

  // First read stage: holds when the port is idle, or on a write in NO_CHANGE.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage1 <= '0;
    end else if (ce && !((RDW_MODE == RDW_NO_CHANGE) && (|we))) begin
      stage1 <= next_word;
    end
  end

  generate
    if (OUTREG != 0) begin : g_outreg
      logic            stage1_valid;
      logic [DATA-1:0] stage2;

      // Output stage advances only one cycle after an enabled access.
      always_ff @(posedge clk) begin
        if (reset) begin
          stage1_valid <= 1'b0;
          stage2       <= '0;
        end else begin
          stage1_valid <= ce;
          if (stage1_valid) stage2 <= stage1;
        end
      end

      assign read = stage2;
    end else begin : g_noreg
      assign read = stage1;
    end
  endgenerate

endmodule

// File: rtl/bram_2psync_be.sv
// True dual-port synchronous block RAM with per-byte write enables,
// selectable read-during-write mode, optional output register and
// cross-port write-collision flag.
module bram_2psync_be
  import bram_pkg::*;
#(
  parameter int DATA     = 32,
  parameter int ADDR     = 10,
  parameter int RDW_MODE = RDW_READ_FIRST,
  parameter int OUTREG   = 0,
  localparam int BYTES   = DATA / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_ce,
  input  logic [BYTES-1:0] a_we,
  input  logic [ADDR-1:0]  a_addr,
  input  logic [DATA-1:0]  a_write,
  output logic [DATA-1:0]  a_read,
  input  logic             b_ce,
  input  logic [BYTES-1:0] b_we,
  input  logic [ADDR-1:0]  b_addr,
  input  logic [DATA-1:0]  b_write,
  output logic [DATA-1:0]  b_read,
  output logic             collision
);

  logic [DATA-1:0] mem [0:(1<<ADDR)-1];
  logic [DATA-1:0] a_word;
  logic [DATA-1:0] b_word;
  logic            coll_now;
  logic            coll_q;

  assign a_word = mem[a_addr];
  assign b_word = mem[b_addr];

  // Byte-lane writes from both ports; port A is applied last so it wins
  // overlapping lanes of a shared address. Writes during reset are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < BYTES; i++) begin
        if (b_ce && b_we[i]) mem[b_addr][8*i +: 8] <= b_write[8*i +: 8];
        if (a_ce && a_we[i]) mem[a_addr][8*i +: 8] <= a_write[8*i +: 8];
      end
    end
  end

  bram_rdport #(
    .DATA(DATA), .ADDR(ADDR), .RDW_MODE(RDW_MODE), .OUTREG(OUTREG), .OWN_WINS(1)
  ) u_rd_a (
    .clk(clk), .reset(reset),
    .ce(a_ce), .we(a_we), .addr(a_addr), .write(a_write),
    .other_ce(b_ce), .other_we(b_we), .other_addr(b_addr), .other_write(b_write),
    .mem_word(a_word), .read(a_read)
  );

  bram_rdport #(
    .DATA(DATA), .ADDR(ADDR), .RDW_MODE(RDW_MODE), .OUTREG(OUTREG), .OWN_WINS(0)
  ) u_rd_b (
    .clk(clk), .reset(reset),
    .ce(b_ce), .we(b_we), .addr(b_addr), .write(b_write),
    .other_ce(a_ce), .other_we(a_we), .other_addr(a_addr), .other_write(a_write),
    .mem_word(b_word), .read(b_read)
  );

  assign coll_now = a_ce && b_ce && (a_addr == b_addr) && (|(a_we & b_we));

  // Collision flag, first stage aligned with single-cycle read data.
  always_ff @(posedge clk) begin
    if (reset) coll_q <= 1'b0;
    else       coll_q <= coll_now;
  end

  generate
    if (OUTREG != 0) begin : g_coll_reg
      logic coll_q2;

      // Extra stage keeps the flag aligned with the pipelined read data.
      always_ff @(posedge clk) begin
        if (reset) coll_q2 <= 1'b0;
        else       coll_q2 <= coll_q;
      end

      assign collision = coll_q2;
    end else begin : g_coll_direct
      assign collision = coll_q;
    end
  endgenerate

endmodule

// File: tb/tb_bram_2psync_be.sv
// Checks four configurations side by side on shared stimulus:
// inst 0..2 = READ_FIRST / WRITE_FIRST / NO_CHANGE with OUTREG=0,
// inst 3 = WRITE_FIRST with OUTREG=1.
module tb_bram_2psync_be;

  logic        clk;
  logic        reset;
  logic        a_ce, b_ce;
  logic [3:0]  a_we, b_we;
  logic [9:0]  a_addr, b_addr;
  logic [31:0] a_write, b_write;
  logic [31:0] ra [4];
  logic [31:0] rb [4];
  logic        col [4];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // reference model state
  logic [31:0] mem_m [1024];
  logic [31:0] exp_a [4];
  logic [31:0] exp_b [4];
  logic        exp_col [4];
  logic [31:0] pipe_a, pipe_b;
  logic        pipe_va, pipe_vb, pipe_col;

  bram_2psync_be #(.DATA(32), .ADDR(10), .RDW_MODE(0), .OUTREG(0)) u_rf (
    .clk(clk), .reset(reset),
    .a_ce(a_ce), .a_we(a_we), .a_addr(a_addr), .a_write(a_write), .a_read(ra[0]),
    .b_ce(b_ce), .b_we(b_we), .b_addr(b_addr), .b_write(b_write), .b_read(rb[0]),
    .collision(col[0]));

  bram_2psync_be #(.DATA(32), .ADDR(10), .RDW_MODE(1), .OUTREG(0)) u_wf (
    .clk(clk), .reset(reset),
    .a_ce(a_ce), .a_we(a_we), .a_addr(a_addr), .a_write(a_write), .a_read(ra[1]),
    .b_ce(b_ce), .b_we(b_we), .b_addr(b_addr), .b_write(b_write), .b_read(rb[1]),
    .collision(col[1]));

  bram_2psync_be #(.DATA(32), .ADDR(10), .RDW_MODE(2), .OUTREG(0)) u_nc (
    .clk(clk), .reset(reset),
    .a_ce(a_ce), .a_we(a_we), .a_addr(a_addr), .a_write(a_write), .a_read(ra[2]),
    .b_ce(b_ce), .b_we(b_we), .b_addr(b_addr), .b_write(b_write), .b_read(rb[2]),
    .collision(col[2]));

  bram_2psync_be #(.DATA(32), .ADDR(10), .RDW_MODE(1), .OUTREG(1)) u_wf_or (
    .clk(clk), .reset(reset),
    .a_ce(a_ce), .a_we(a_we), .a_addr(a_addr), .a_write(a_write), .a_read(ra[3]),
    .b_ce(b_ce), .b_we(b_we), .b_addr(b_addr), .b_write(b_write), .b_read(rb[3]),
    .collision(col[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, want, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [31:0] old_a, old_b, new_a, new_b;
    logic [3:0]  wa, wb;
    logic        coll;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        exp_a[i] = '0; exp_b[i] = '0; exp_col[i] = 1'b0;
      end
      pipe_a = '0; pipe_b = '0; pipe_va = 1'b0; pipe_vb = 1'b0; pipe_col = 1'b0;
      return;
    end
    old_a = mem_m[a_addr];
    old_b = mem_m[b_addr];
    wa = a_ce ? a_we : 4'b0;
    wb = b_ce ? b_we : 4'b0;
    for (int i = 0; i < 4; i++)
      if (wb[i]) mem_m[b_addr][8*i +: 8] = b_write[8*i +: 8];
    for (int i = 0; i < 4; i++)
      if (wa[i]) mem_m[a_addr][8*i +: 8] = a_write[8*i +: 8];
    new_a = mem_m[a_addr];
    new_b = mem_m[b_addr];
    coll = a_ce && b_ce && (a_addr == b_addr) && ((a_we & b_we) != 0);

    if (a_ce) begin
      exp_a[0] = old_a;
      exp_a[1] = new_a;
      if (wa == 0) exp_a[2] = old_a;
    end
    if (b_ce) begin
      exp_b[0] = old_b;
      exp_b[1] = new_b;
      if (wb == 0) exp_b[2] = old_b;
    end
    for (int i = 0; i < 3; i++) exp_col[i] = coll;

    if (pipe_va) exp_a[3] = pipe_a;
    if (pipe_vb) exp_b[3] = pipe_b;
    pipe_va = a_ce;
    pipe_vb = b_ce;
    if (a_ce) pipe_a = new_a;
    if (b_ce) pipe_b = new_b;
    exp_col[3] = pipe_col;
    pipe_col = coll;
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("a_read[%0d]", i), ra[i], exp_a[i]);
        chk($sformatf("b_read[%0d]", i), rb[i], exp_b[i]);
        chk($sformatf("collision[%0d]", i), 32'(col[i]), 32'(exp_col[i]));
      end
    end
  endtask

  task automatic drv(input logic ace, input logic [3:0] awe, input logic [9:0] aad,
                     input logic [31:0] awr, input logic bce, input logic [3:0] bwe,
                     input logic [9:0] bad, input logic [31:0] bwr);
    a_ce = ace; a_we = awe; a_addr = aad; a_write = awr;
    b_ce = bce; b_we = bwe; b_addr = bad; b_write = bwr;
    cycle();
  endtask

  task automatic idle();
    drv(0, 4'h0, 10'h0, 32'h0, 0, 4'h0, 10'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    a_ce = 0; a_we = 0; a_addr = 0; a_write = 0;
    b_ce = 0; b_we = 0; b_addr = 0; b_write = 0;

    // preload known contents; outputs are unchecked until reset clears them
    for (int i = 0; i < 16; i++) drv(1, 4'hF, 10'(i), $urandom, 0, 4'h0, 10'h0, 32'h0);
    drv(1, 4'hF, 10'h020, 32'h11111111, 0, 4'h0, 10'h0, 32'h0);
    drv(1, 4'hF, 10'h030, 32'h12345678, 0, 4'h0, 10'h0, 32'h0);
    drv(1, 4'hF, 10'h040, 32'h55555555, 0, 4'h0, 10'h0, 32'h0);
    drv(1, 4'hF, 10'h050, 32'h0BADF00D, 0, 4'h0, 10'h0, 32'h0);

    // reset for two cycles
    chk_en = 1;
    reset = 1'b1;
    idle(); idle();
    reset = 1'b0;
    chk("rst_a_read", ra[0], 32'h0);
    chk("rst_b_read", rb[3], 32'h0);
    chk("rst_collision", 32'(col[1]), 32'h0);

    // full and partial byte writes
    drv(1, 4'hF, 10'h010, 32'hDEADBEEF, 0, 4'h0, 10'h0, 32'h0);
    drv(0, 4'h0, 10'h0, 32'h0, 1, 4'h0, 10'h010, 32'h0);
    chk("full_write_rd", rb[0], 32'hDEADBEEF);
    drv(1, 4'h1, 10'h010, 32'h000000AA, 0, 4'h0, 10'h0, 32'h0);
    drv(1, 4'h0, 10'h010, 32'h0, 1, 4'h0, 10'h010, 32'h0);
    chk("partial_write_rd", rb[0], 32'hDEADBEAA);

    // same-port read-during-write
    drv(1, 4'hF, 10'h020, 32'h22222222, 0, 4'h0, 10'h0, 32'h0);
    chk("rdw_read_first", ra[0], 32'h11111111);
    chk("rdw_write_first", ra[1], 32'h22222222);
    chk("rdw_no_change", ra[2], 32'hDEADBEAA);

    // cross-port bypass
    drv(1, 4'hC, 10'h030, 32'hCAFE0000, 1, 4'h0, 10'h030, 32'h0);
    chk("bypass_wf", rb[1], 32'hCAFE5678);
    chk("bypass_rf_old", rb[0], 32'h12345678);
    chk("bypass_no_coll", 32'(col[1]), 32'h0);

    // write collision
    drv(1, 4'h3, 10'h040, 32'hAAAAAAAA, 1, 4'h6, 10'h040, 32'hBBBBBBBB);
    chk("coll_pulse", 32'(col[0]), 32'h1);
    chk("coll_or_late", 32'(col[3]), 32'h0);
    drv(0, 4'h0, 10'h0, 32'h0, 1, 4'h0, 10'h040, 32'h0);
    chk("coll_one_cycle", 32'(col[0]), 32'h0);
    chk("coll_or_pulse", 32'(col[3]), 32'h1);
    chk("coll_merge", rb[0], 32'h55BBAAAA);

    // pipelined read: 2-cycle latency, hold while idle, reset flush
    drv(0, 4'h0, 10'h0, 32'h0, 1, 4'h0, 10'h010, 32'h0);
    idle();
    chk("or_latency2", rb[3], 32'hDEADBEAA);
    for (int k = 0; k < 3; k++) begin
      drv(0, 4'h0, 10'h0, 32'h0, 0, 4'h0, 10'h030, 32'h0);
      chk("or_hold", rb[3], 32'hDEADBEAA);
    end
    drv(0, 4'h0, 10'h0, 32'h0, 1, 4'h0, 10'h030, 32'h0);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("or_reset_flush", rb[3], 32'h0);
    idle();
    chk("or_read_suppressed", rb[3], 32'h0);
    drv(0, 4'h0, 10'h0, 32'h0, 1, 4'h0, 10'h030, 32'h0);
    idle();
    chk("or_after_reset", rb[3], 32'hCAFE5678);

    // write during reset is discarded
    reset = 1'b1;
    drv(1, 4'hF, 10'h050, 32'hFFFFFFFF, 0, 4'h0, 10'h0, 32'h0);
    reset = 1'b0;
    drv(0, 4'h0, 10'h0, 32'h0, 1, 4'h0, 10'h050, 32'h0);
    chk("reset_write_dropped", rb[0], 32'h0BADF00D);

    // randomized traffic over a small address window to provoke overlaps
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      drv($urandom_range(0, 3) != 0, 4'($urandom), 10'($urandom_range(0, 3)), $urandom,
          $urandom_range(0, 3) != 0, 4'($urandom), 10'($urandom_range(0, 3)), $urandom);
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
